rot_frame_tx: RTL and testbench
===============================

Name: rot_frame_tx

Overview:
- Parametrised framer that snapshots N rotary-decoder counters and streams them as a checksummed byte frame through the existing uart_tx start/busy handshake.
- Generalises the fixed 3×24-bit packet sequencer: channel count, counter width, header byte and frame period are configurable.
- Adds enable and overrun reporting.
- Sits between the decoder1 instances and uart_tx in the top level.

Parameters:
- CHANNELS, 3: number of counter channels (1..16)
- BITS, 24: counter width per channel (1..32); bytes per channel NB = ceil(BITS/8)
- HEADER, 8'h5A: first byte of every frame
- PERIOD, 5000000: clk cycles between frame starts (≥ 2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- en  in  1  frame generation enable
- cnt_in  in  CHANNELS*BITS  flat counter bus, channel 0 in LSBs
- tx_busy  in  1  uart_tx busy (may be slower clock domain, pre-synchronised)
- tx_start  out  1  byte send request (level, held until acknowledged)
- tx_data  out  8  byte to send
- frame_active  out  1  high from snapshot to end of checksum byte
- overrun  out  1  sticky: period expired while frame active

Behaviour:
- Reset: tx_start=0, tx_data=0, frame_active=0, overrun=0, period timer=0, state IDLE, byte index=0, checksum=0.
- Period timer: free-runs 0..PERIOD-1 while en=1; held at 0 while en=0.
- Frame trigger: timer==PERIOD-1.
  - In IDLE: start a frame.
  - Frame active: set overrun (sticky until rst); the trigger is dropped, not queued.
- Frame layout: HEADER, [SEQ], then per channel 0..CHANNELS-1, NB bytes LSB first (bits above BITS zero), then CS.
- CS = 8-bit mod-256 sum of every byte after HEADER, excluding CS itself.
- States:
  - IDLE: wait for trigger.
  - LOAD: one cycle; latch entire cnt_in into a snapshot register, clear checksum, index=0, frame_active=1.
  - SEND: drive tx_data with the current byte, assert tx_start.
  - ACK: hold tx_start and tx_data until tx_busy=1; then deassert tx_start, add the byte to the checksum (skip for HEADER and CS).
  - DONE: wait tx_busy=0; if last byte, go to IDLE and drop frame_active; else index+1 and go to SEND.
- Snapshot latched only in LOAD. cnt_in changes mid-frame never alter the frame.
- tx_data is stable for the whole time tx_start is high. Never assert tx_start while tx_busy=1 in SEND entry; SEND waits for tx_busy=0.
- en falling mid-frame: the current frame completes. No new trigger follows.
- rst mid-frame: immediate return to reset values. tx_start drops the same cycle. A partial frame on the line is acceptable.
- Latency: LOAD occurs the cycle after trigger; tx_start rises the cycle after LOAD.

Optional Feature:
- Macro FRAME_SEQ_EN.
- Defined: an 8-bit sequence byte follows HEADER.
  - Value is the frame counter: reset 0, +1 per completed frame, wraps 255→0.
  - Included in CS.
  - Frame length = 3 + CHANNELS*NB.
- Undefined: no SEQ byte, no counter logic; frame length = 2 + CHANNELS*NB.

Test Plan:
- Defaults, FRAME_SEQ_EN undefined, cnt_in = {24'h000001, 24'hABCDEF, 24'h123456}, uart model busy 3 cycles after start for 20 cycles → bytes 5A 56 34 12 EF CD AB 01 00 00 04, frame_active low after the last byte.
- BITS=12, CHANNELS=2, cnt_in = {12'h001, 12'hABC} → 5A BC 0A 01 00 C7; upper nibbles zero.
- PERIOD=50, uart busy 200 cycles per byte → overrun=1 at the first trigger inside the frame, stays 1; frame still completes correctly.
- FRAME_SEQ_EN defined, three frames with cnt_in constant 0 → SEQ bytes 00, 01, 02; CS equals SEQ each frame.
- Change cnt_in every cycle during a frame → transmitted data equals the value latched at LOAD; tx_start never rises while tx_busy=1.
- rst asserted while in ACK → next cycle tx_start=0, frame_active=0; after release with en=1 the first frame starts at timer==PERIOD-1.

Source files
------------

// File: rtl/rot_frame_tx.sv
// Snapshots CHANNELS rotary counters every PERIOD clocks and streams them as a checksummed
// byte frame over the uart_tx start/busy handshake. Optional SEQ byte enabled by FRAME_SEQ_EN.
module rot_frame_tx #(
  parameter int         CHANNELS = 3,
  parameter int         BITS     = 24,
  parameter logic [7:0] HEADER   = 8'h5A,
  parameter int         PERIOD   = 5000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CHANNELS*BITS-1:0] cnt_in,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     frame_active,
  output logic                     overrun
);
  localparam int NB         = (BITS + 7) / 8;
  localparam int DATA_BYTES = CHANNELS * NB;
`ifdef FRAME_SEQ_EN
  localparam int DATA_OFF   = 2;
`else
  localparam int DATA_OFF   = 1;
`endif
  localparam int FRAME_LEN  = DATA_BYTES + DATA_OFF + 1;
  localparam int IDX_W      = $clog2(FRAME_LEN);
  localparam int SLOTS      = 2 ** IDX_W;
  localparam int TIMER_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(PERIOD - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, ACK, DONE} state_t;

  state_t                   state_reg;
  logic [TIMER_W-1:0]       timer_reg;
  logic [CHANNELS*BITS-1:0] snap_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [7:0]               cs_reg;
  logic                     tx_start_reg;
  logic [7:0]               tx_data_reg;
  logic                     frame_active_reg;
  logic                     overrun_reg;
`ifdef FRAME_SEQ_EN
  logic [7:0]               seq_reg;
`endif

  logic                     trigger;
  logic                     counted;
  logic [7:0]               cur_byte;
  logic [SLOTS-1:0][7:0]    byte_lut;

  assign tx_start     = tx_start_reg;
  assign tx_data      = tx_data_reg;
  assign frame_active = frame_active_reg;
  assign overrun      = overrun_reg;

  assign trigger = en && (timer_reg == TIMER_MAX);
  // HEADER and CS are the only bytes left out of the running checksum.
  assign counted = (idx_reg != '0) && (idx_reg != LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst || !en || timer_reg == TIMER_MAX) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + TIMER_W'(1);
    end
  end

  // Byte slot table: each data slot picks its channel/byte out of the snapshot,
  // zero-filling the bits above BITS in the last byte of each channel.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      if (gi >= DATA_OFF && gi < DATA_OFF + DATA_BYTES) begin : g_data
        localparam int CH = (gi - DATA_OFF) / NB;
        localparam int BY = (gi - DATA_OFF) % NB;
        localparam int LO = CH * BITS + BY * 8;
        localparam int W  = (BITS - BY * 8 >= 8) ? 8 : (BITS - BY * 8);
        assign byte_lut[gi] = 8'(snap_reg[LO +: W]);
      end else begin : g_fixed
        assign byte_lut[gi] = 8'h00;
      end
    end
  endgenerate

  always_comb begin
    cur_byte = byte_lut[idx_reg];
    if (idx_reg == '0) begin
      cur_byte = HEADER;
`ifdef FRAME_SEQ_EN
    end else if (idx_reg == IDX_W'(1)) begin
      cur_byte = seq_reg;
`endif
    end else if (idx_reg == LAST_IDX) begin
      cur_byte = cs_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      snap_reg         <= '0;
      idx_reg          <= '0;
      cs_reg           <= '0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= '0;
      frame_active_reg <= 1'b0;
      overrun_reg      <= 1'b0;
`ifdef FRAME_SEQ_EN
      seq_reg          <= '0;
`endif
    end else begin
      if (trigger && state_reg != IDLE) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (trigger) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          snap_reg         <= cnt_in;
          cs_reg           <= '0;
          idx_reg          <= '0;
          frame_active_reg <= 1'b1;
          // The header needs no snapshot data, so it can go out right away.
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= HEADER;
            state_reg    <= ACK;
          end else begin
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start_reg <= 1'b1;
            tx_data_reg  <= cur_byte;
            state_reg    <= ACK;
          end
        end
        ACK: begin
          if (tx_busy) begin
            tx_start_reg <= 1'b0;
            if (counted) begin
              cs_reg <= cs_reg + tx_data_reg;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (!tx_busy) begin
            if (idx_reg == LAST_IDX) begin
              frame_active_reg <= 1'b0;
`ifdef FRAME_SEQ_EN
              seq_reg          <= seq_reg + 8'd1;
`endif
              state_reg        <= IDLE;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= SEND;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rot_frame_tx.sv
// Bench for rot_frame_tx: a 3x24 instance and a 2x12 instance, each fed by a uart busy model;
// expected frames are queued when counters are presented and compared as bytes arrive.
module tb_rot_frame_tx;
  localparam int PERIOD_T = 500;
`ifdef FRAME_SEQ_EN
  localparam int FL_A = 12;
  localparam int FL_B = 7;
`else
  localparam int FL_A = 11;
  localparam int FL_B = 6;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [71:0] cnt_a = '0;
  logic [23:0] cnt_b = '0;
  logic        tx_busy_a = 1'b0;
  logic        tx_busy_b = 1'b0;
  logic        tx_start_a, tx_start_b, frame_active_a, frame_active_b, overrun_a, overrun_b;
  logic [7:0]  tx_data_a, tx_data_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_seq = 0;
  int busy_len = 20;
  int a_delay = 0, a_busy = 0, b_delay = 0, b_busy = 0;
  logic [7:0] rx_q[$], exp_q[$], rx_qb[$], exp_qb[$];

  always #5 clk = ~clk;

  rot_frame_tx #(.CHANNELS(3), .BITS(24), .HEADER(8'h5A), .PERIOD(PERIOD_T)) dut (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_a), .tx_busy(tx_busy_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .frame_active(frame_active_a), .overrun(overrun_a));

  rot_frame_tx #(.CHANNELS(2), .BITS(12), .HEADER(8'h5A), .PERIOD(PERIOD_T)) dut_narrow (
    .clk(clk), .rst(rst), .en(en), .cnt_in(cnt_b), .tx_busy(tx_busy_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .frame_active(frame_active_b), .overrun(overrun_b));

  // uart model A: captures on start, raises busy 3 cycles later for busy_len cycles
  always @(posedge clk) begin
    if (a_delay > 0) begin
      a_delay <= a_delay - 1;
      if (a_delay == 1) begin
        tx_busy_a <= 1'b1;
        a_busy    <= busy_len;
      end
    end else if (tx_busy_a) begin
      if (a_busy <= 1) tx_busy_a <= 1'b0;
      a_busy <= a_busy - 1;
    end else if (tx_start_a) begin
      rx_q.push_back(tx_data_a);
      a_delay <= 3;
    end
  end

  always @(posedge clk) begin
    if (b_delay > 0) begin
      b_delay <= b_delay - 1;
      if (b_delay == 1) begin
        tx_busy_b <= 1'b1;
        b_busy    <= 4;
      end
    end else if (tx_busy_b) begin
      if (b_busy <= 1) tx_busy_b <= 1'b0;
      b_busy <= b_busy - 1;
    end else if (tx_start_b) begin
      rx_qb.push_back(tx_data_b);
      b_delay <= 1;
    end
  end

  task automatic push_exp_a(input logic [71:0] cnt);
    logic [7:0]  cs;
    logic [23:0] v;
    cs = 8'h00;
    exp_q.push_back(8'h5A);
`ifdef FRAME_SEQ_EN
    exp_q.push_back(8'(exp_seq));
    cs = 8'(exp_seq);
`endif
    for (int ch = 0; ch < 3; ch++) begin
      v = cnt[ch*24 +: 24];
      exp_q.push_back(v[7:0]);
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[23:16]);
      cs = cs + v[7:0] + v[15:8] + v[23:16];
    end
    exp_q.push_back(cs);
  endtask

  task automatic push_exp_b(input logic [23:0] cnt);
    logic [7:0]  cs;
    logic [15:0] v;
    cs = 8'h00;
    exp_qb.push_back(8'h5A);
`ifdef FRAME_SEQ_EN
    exp_qb.push_back(8'(exp_seq));
    cs = 8'(exp_seq);
`endif
    for (int ch = 0; ch < 2; ch++) begin
      v = {4'h0, cnt[ch*12 +: 12]};
      exp_qb.push_back(v[7:0]);
      exp_qb.push_back(v[15:8]);
      cs = cs + v[7:0] + v[15:8];
    end
    exp_qb.push_back(cs);
  endtask

  task automatic wait_start(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int n = 0; n < 4 * PERIOD_T; n++) begin
      @(negedge clk);
      if (frame_active_a) begin
        ok  = 1'b1;
        cyc = n + 1;
        rx_q.delete();
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      @(negedge clk);
      if (!frame_active_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec_cnt++; if (tx_start_a !== 1'b0) begin err_cnt++; $display("FAIL reset tx_start: got %b expected 0", tx_start_a); end
    vec_cnt++; if (tx_data_a !== 8'h00) begin err_cnt++; $display("FAIL reset tx_data: got %h expected 00", tx_data_a); end
    vec_cnt++; if (frame_active_a !== 1'b0) begin err_cnt++; $display("FAIL reset frame_active: got %b expected 0", frame_active_a); end
    vec_cnt++; if (overrun_a !== 1'b0) begin err_cnt++; $display("FAIL reset overrun: got %b expected 0", overrun_a); end
    vec_cnt++; if ({tx_start_b, tx_data_b, frame_active_b, overrun_b} !== 11'h0) begin
      err_cnt++; $display("FAIL reset narrow outputs: got %h expected 000", {tx_start_b, tx_data_b, frame_active_b, overrun_b});
    end
    $display("reset outputs checked");
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_first_frame();
    bit ok; int cyc; logic [7:0] got, exp;
    cnt_a = {24'h000001, 24'hABCDEF, 24'h123456};
    cnt_b = {12'h001, 12'hABC};
    en = 1'b1;
    wait_start(ok, cyc);
    push_exp_a(cnt_a);
    push_exp_b(cnt_b);
    vec_cnt++; if (!ok || cyc != PERIOD_T + 1) begin err_cnt++; $display("FAIL first latency: got %0d cycles expected %0d", cyc, PERIOD_T + 1); end
    vec_cnt++; if (tx_start_a !== 1'b1) begin err_cnt++; $display("FAIL first tx_start after load: got %b expected 1", tx_start_a); end
    wait_done(ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL first frame_active end: timeout"); end
    vec_cnt++; if (rx_q.size() != FL_A) begin err_cnt++; $display("FAIL first length: got %0d expected %0d", rx_q.size(), FL_A); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); exp = exp_q.pop_front(); vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL first byte: got %h expected %h", got, exp); end
      else $display("first byte %h", got);
    end
    exp_q.delete();
  endtask

  task automatic test_narrow();
    logic [7:0] got, exp;
    vec_cnt++; if (frame_active_b !== 1'b0) begin err_cnt++; $display("FAIL narrow frame_active: got %b expected 0", frame_active_b); end
    vec_cnt++; if (rx_qb.size() != FL_B) begin err_cnt++; $display("FAIL narrow length: got %0d expected %0d", rx_qb.size(), FL_B); end
    while (rx_qb.size() > 0 && exp_qb.size() > 0) begin
      got = rx_qb.pop_front(); exp = exp_qb.pop_front(); vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL narrow byte: got %h expected %h", got, exp); end
      else $display("narrow byte %h", got);
    end
    exp_qb.delete();
    exp_seq++;
  endtask

  task automatic test_zero_frames();
    bit ok; int cyc; logic [7:0] got, exp;
    cnt_a = '0;
    for (int f = 0; f < 3; f++) begin
      wait_start(ok, cyc);
      push_exp_a(cnt_a);
      wait_done(ok);
      vec_cnt++; if (rx_q.size() != FL_A) begin err_cnt++; $display("FAIL zero length: got %0d expected %0d", rx_q.size(), FL_A); end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
        got = rx_q.pop_front(); exp = exp_q.pop_front(); vec_cnt++;
        if (got !== exp) begin err_cnt++; $display("FAIL zero byte: got %h expected %h", got, exp); end
        else $display("zero frame %0d byte %h", f, got);
      end
      exp_q.delete();
      exp_seq++;
    end
  endtask

  task automatic test_snapshot();
    bit ok; int cyc; logic [7:0] got, exp, prev_data; logic prev_start;
    cnt_a = 72'({$urandom(), $urandom(), $urandom()});
    wait_start(ok, cyc);
    push_exp_a(cnt_a);
    prev_start = tx_start_a;
    prev_data  = tx_data_a;
    for (int n = 0; n < 40000; n++) begin
      @(negedge clk);
      cnt_a = 72'({$urandom(), $urandom(), $urandom()});
      if (tx_start_a && !prev_start) begin
        vec_cnt++;
        if (tx_busy_a) begin err_cnt++; $display("FAIL snapshot start while busy: busy %b expected 0", tx_busy_a); end
      end
      if (tx_start_a && prev_start && tx_data_a !== prev_data) begin
        vec_cnt++; err_cnt++; $display("FAIL snapshot data stability: got %h expected %h", tx_data_a, prev_data);
      end
      prev_start = tx_start_a;
      prev_data  = tx_data_a;
      if (!frame_active_a) break;
    end
    vec_cnt++; if (rx_q.size() != FL_A) begin err_cnt++; $display("FAIL snapshot length: got %0d expected %0d", rx_q.size(), FL_A); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); exp = exp_q.pop_front(); vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL snapshot byte: got %h expected %h", got, exp); end
      else $display("snapshot byte %h", got);
    end
    exp_q.delete();
    exp_seq++;
  endtask

  task automatic test_overrun();
    bit ok; int cyc; int first; logic [7:0] got, exp;
    busy_len = 200;
    wait_start(ok, cyc);
    push_exp_a(cnt_a);
    vec_cnt++; if (overrun_a !== 1'b0) begin err_cnt++; $display("FAIL overrun before trigger: got %b expected 0", overrun_a); end
    first = -1;
    for (int n = 1; n < 40000; n++) begin
      @(negedge clk);
      if (overrun_a && first < 0) first = n;
      if (!frame_active_a) break;
    end
    vec_cnt++; if (first != PERIOD_T - 1) begin err_cnt++; $display("FAIL overrun timing: got %0d cycles expected %0d", first, PERIOD_T - 1); end
    vec_cnt++; if (overrun_a !== 1'b1) begin err_cnt++; $display("FAIL overrun sticky: got %b expected 1", overrun_a); end
    vec_cnt++; if (rx_q.size() != FL_A) begin err_cnt++; $display("FAIL overrun length: got %0d expected %0d", rx_q.size(), FL_A); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); exp = exp_q.pop_front(); vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL overrun byte: got %h expected %h", got, exp); end
      else $display("overrun frame byte %h", got);
    end
    exp_q.delete();
    exp_seq++;
    busy_len = 20;
  endtask

  task automatic test_en_low();
    bit ok; bit seen; int cyc; logic [7:0] got, exp;
    wait_start(ok, cyc);
    push_exp_a(cnt_a);
    repeat (100) @(negedge clk);
    en = 1'b0;
    wait_done(ok);
    vec_cnt++; if (rx_q.size() != FL_A) begin err_cnt++; $display("FAIL en_low length: got %0d expected %0d", rx_q.size(), FL_A); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); exp = exp_q.pop_front(); vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL en_low byte: got %h expected %h", got, exp); end
      else $display("en_low byte %h", got);
    end
    exp_q.delete();
    exp_seq++;
    seen = 1'b0;
    repeat (2 * PERIOD_T) begin
      @(negedge clk);
      if (frame_active_a) seen = 1'b1;
    end
    vec_cnt++; if (seen) begin err_cnt++; $display("FAIL en_low quiet: got a frame expected none"); end
    en = 1'b1;
    wait_start(ok, cyc);
    vec_cnt++; if (!ok || cyc != PERIOD_T + 1) begin err_cnt++; $display("FAIL en_low restart latency: got %0d expected %0d", cyc, PERIOD_T + 1); end
    wait_done(ok);
    $display("en_low restart frame of %0d bytes", rx_q.size());
    exp_seq++;
  endtask

  task automatic test_reset_mid();
    bit ok; bit hit; int cyc; logic [7:0] got, exp;
    wait_start(ok, cyc);
    hit = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (rx_q.size() >= 3 && tx_start_a && !tx_busy_a) begin
        hit = 1'b1;
        break;
      end
    end
    vec_cnt++; if (!hit) begin err_cnt++; $display("FAIL reset_mid reach ack: timeout"); end
    rst = 1'b1;
    @(negedge clk);
    vec_cnt++; if (tx_start_a !== 1'b0) begin err_cnt++; $display("FAIL reset_mid tx_start: got %b expected 0", tx_start_a); end
    vec_cnt++; if (frame_active_a !== 1'b0) begin err_cnt++; $display("FAIL reset_mid frame_active: got %b expected 0", frame_active_a); end
    vec_cnt++; if (overrun_a !== 1'b0) begin err_cnt++; $display("FAIL reset_mid overrun: got %b expected 0", overrun_a); end
    vec_cnt++; if (tx_data_a !== 8'h00) begin err_cnt++; $display("FAIL reset_mid tx_data: got %h expected 00", tx_data_a); end
    rst = 1'b0;
    exp_seq = 0;
    cnt_a = {24'hFEDCBA, 24'h00FF00, 24'h800001};
    wait_start(ok, cyc);
    push_exp_a(cnt_a);
    vec_cnt++; if (!ok || cyc != PERIOD_T + 1) begin err_cnt++; $display("FAIL reset_mid restart latency: got %0d expected %0d", cyc, PERIOD_T + 1); end
    wait_done(ok);
    vec_cnt++; if (rx_q.size() != FL_A) begin err_cnt++; $display("FAIL reset_mid length: got %0d expected %0d", rx_q.size(), FL_A); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); exp = exp_q.pop_front(); vec_cnt++;
      if (got !== exp) begin err_cnt++; $display("FAIL reset_mid byte: got %h expected %h", got, exp); end
      else $display("reset_mid byte %h", got);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_narrow();
    test_zero_frames();
    test_snapshot();
    test_overrun();
    test_en_low();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
